// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronises the PS/2 lines, deframes 11-bit frames,
// checks start/parity/stop and queues good scancodes behind a valid/ready port.
//
// state   | meaning
// IDLE    | waiting for a start bit (falling edge with data low)
// RECEIVE | shifting in data, parity and stop bits; watching for timeout
// CHECK   | one cycle: verify parity/stop, push byte or flag frame_error
module ps2_keyboard_rx #(
    parameter int TIMEOUT_CYCLES = 32000,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       keyboard_clock,
    input  logic       keyboard_data,
    output logic [7:0] code,
    output logic       code_valid,
    input  logic       code_ready,
    output logic       frame_error,
    output logic       overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, RECEIVE, CHECK} state_t;
    state_t state, state_next;

    logic          clk_s1, clk_s2, clk_s3;
    logic          dat_s1, dat_s2;
    logic          fe;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] to_cnt;
    logic [7:0]    shift;
    logic          parity, stop;
    logic          good, push_req, push, pop, full, empty;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;

    always_ff @(posedge CLK) begin
        if (reset) begin
            {clk_s1, clk_s2, clk_s3, dat_s1, dat_s2} <= '1;
        end else begin
            clk_s1 <= keyboard_clock;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= keyboard_data;
            dat_s2 <= dat_s1;
        end
    end

    assign fe   = !clk_s2 && clk_s3;
    assign good = (^{shift, parity}) && stop;

    always_comb begin
        state_next  = state;
        frame_error = 1'b0;
        push_req    = 1'b0;
        case (state)
            IDLE: begin
                if (fe) begin
                    if (!dat_s2) state_next = RECEIVE;
                    else         frame_error = 1'b1;
                end
            end
            RECEIVE: begin
                if (fe) begin
                    if (bit_cnt == 4'd9) state_next = CHECK;
                end else if (to_cnt == TO_LAST) begin
                    frame_error = 1'b1;
                    state_next  = IDLE;
                end
            end
            CHECK: begin
                state_next = IDLE;
                if (good) push_req    = 1'b1;
                else      frame_error = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= IDLE;
            bit_cnt <= '0;
            to_cnt  <= '0;
            shift   <= '0;
            parity  <= 1'b0;
            stop    <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && fe && !dat_s2) begin
                bit_cnt <= '0;
                to_cnt  <= '0;
            end else if (state == RECEIVE) begin
                if (fe) begin
                    to_cnt  <= '0;
                    bit_cnt <= bit_cnt + 4'd1;
                    // data arrives LSB first, so shift in from the top
                    if (bit_cnt < 4'd8)       shift  <= {dat_s2, shift[7:1]};
                    else if (bit_cnt == 4'd8) parity <= dat_s2;
                    else                      stop   <= dat_s2;
                end else begin
                    to_cnt <= to_cnt + TW'(1);
                end
            end
        end
    end

    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign code_valid = !empty;
    assign code       = mem[rd_ptr[AW-1:0]];
    assign pop        = code_valid && code_ready;
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign push       = push_req && (!full || pop);
    assign overflow   = push_req && full && !pop;

    always_ff @(posedge CLK) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr[AW-1:0]] <= shift;
                wr_ptr <= wr_ptr + (AW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: frames are modelled at byte level,
// expected codes are queued at send time and a monitor checks every pop.
module tb_ps2_keyboard_rx;
    localparam int TO    = 200;
    localparam int DEPTH = 4;
    localparam int HALF  = 20;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       kb_clk = 1'b1;
    logic       kb_data = 1'b1;
    logic [7:0] code;
    logic       code_valid;
    logic       code_ready = 1'b0;
    logic       frame_error;
    logic       overflow;

    ps2_keyboard_rx #(.TIMEOUT_CYCLES(TO), .FIFO_DEPTH(DEPTH)) dut (
        .CLK(CLK), .reset(reset), .keyboard_clock(kb_clk), .keyboard_data(kb_data),
        .code(code), .code_valid(code_valid), .code_ready(code_ready),
        .frame_error(frame_error), .overflow(overflow)
    );

    always #5 CLK = ~CLK;

    int         cyc = 0;
    int         checks = 0;
    int         passes = 0;
    int         ready_mode = 0;
    int         pulse_cyc = -1;
    bit         pulse_on_check = 1'b0;
    int         last_low_cyc = 0;
    int         err_seen = 0, ovf_seen = 0, exp_err = 0, exp_ovf = 0;
    int         err_cyc = -1, valid_rise_cyc = -1, valid_cycles = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] exp_q[$];

    always @(posedge CLK) cyc <= cyc + 1;

    always @(posedge CLK) begin
        #1;
        if (cyc == pulse_cyc)  code_ready = 1'b1;
        else if (ready_mode == 2) code_ready = 1'($urandom_range(0, 1));
        else                   code_ready = (ready_mode == 1);
    end

    always @(negedge CLK) begin
        if (!reset) begin
            if (code_valid) valid_cycles++;
            if (code_valid && !prev_valid) valid_rise_cyc = cyc;
            prev_valid = code_valid;
            if (code_valid && code_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL pop_unexpected got=%02h expected=none", code);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    if (code !== e) $display("FAIL pop_code got=%02h expected=%02h", code, e);
                    else passes++;
                end
            end
            if (frame_error) begin err_seen++; err_cyc = cyc; end
            if (overflow) ovf_seen++;
            if (frame_error || overflow) begin
                checks++;
                if (frame_error && overflow) $display("FAIL err_ovf_exclusive got=both expected=one");
                else passes++;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        else passes++;
    endtask

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic par_flip,
                                             input logic stop_bad);
        logic par;
        par = (~^b) ^ par_flip;  // odd parity over data+parity
        return {~stop_bad, par, b, 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            kb_data = f[i];
            repeat (HALF) @(negedge CLK);
            kb_clk = 1'b0;
            last_low_cyc = cyc;
            // CHECK falls two edges after the edge that first samples the low stop bit
            if (i == n - 1 && pulse_on_check) pulse_cyc = cyc + 3;
            repeat (HALF) @(negedge CLK);
            kb_clk = 1'b1;
        end
        repeat (HALF) @(negedge CLK);
        kb_data = 1'b1;
    endtask

    task automatic send_and_model(input logic [10:0] f);
        if ((^f[9:1]) && f[10] && !f[0]) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(f[8:1]);
            else exp_ovf++;
        end else begin
            exp_err++;
        end
        send_bits(f, 11);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge CLK);
            n++;
        end
        repeat (4) @(negedge CLK);
        chk(name, exp_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (4) @(posedge CLK);
        @(negedge CLK) reset = 1'b0;
        @(negedge CLK);
        chk("rst_code", code, 0);
        chk("rst_valid", code_valid, 0);
        chk("rst_ferr", frame_error, 0);
        chk("rst_ovf", overflow, 0);

        // 1: single good frame, consumer always ready
        ready_mode = 1;
        valid_cycles = 0;
        valid_rise_cyc = -1;
        send_and_model(mk_frame(8'h1C, 1'b0, 1'b0));
        drain("t1_drain");
        chk("t1_latency", valid_rise_cyc, last_low_cyc + 4);
        chk("t1_valid_cycles", valid_cycles, 1);
        chk("t1_err", err_seen, exp_err);

        // 2: parity error
        valid_cycles = 0;
        send_and_model(mk_frame(8'h1C, 1'b1, 1'b0));
        repeat (10) @(negedge CLK);
        chk("t2_err", err_seen, exp_err);
        chk("t2_valid_cycles", valid_cycles, 0);

        // bad start bit: one falling edge with data high
        send_bits(11'h7FF, 1);
        exp_err++;
        repeat (10) @(negedge CLK);
        chk("bad_start_err", err_seen, exp_err);

        // 3: overflow with consumer stalled
        ready_mode = 0;
        for (int i = 1; i <= 5; i++) send_and_model(mk_frame(8'(i), 1'b0, 1'b0));
        repeat (10) @(negedge CLK);
        chk("t3_ovf", ovf_seen, exp_ovf);
        chk("t3_ovf_exp", exp_ovf, 1);
        ready_mode = 1;
        drain("t3_drain");
        chk("t3_valid_low", code_valid, 0);

        // 4: timeout after start + 4 bits
        send_bits(mk_frame(8'hA5, 1'b0, 1'b0), 5);
        exp_err++;
        repeat (TO + 20) @(negedge CLK);
        chk("t4_err", err_seen, exp_err);
        chk("t4_timing", err_cyc, last_low_cyc + 2 + TO);
        send_and_model(mk_frame(8'hF0, 1'b0, 1'b0));
        drain("t4_drain");
        chk("t4_err_after", err_seen, exp_err);

        // 5: reset in the middle of a frame
        send_bits(mk_frame(8'hE0, 1'b0, 1'b0), 7);
        @(negedge CLK) reset = 1'b1;
        @(negedge CLK) reset = 1'b0;
        @(negedge CLK);
        chk("t5_valid_after_rst", code_valid, 0);
        chk("t5_code_after_rst", code, 0);
        send_and_model(mk_frame(8'h5A, 1'b0, 1'b0));
        drain("t5_drain");
        chk("t5_err", err_seen, exp_err);

        // 6: full FIFO, pop in the CHECK cycle of the next frame
        ready_mode = 0;
        for (int i = 'h11; i <= 'h14; i++) send_and_model(mk_frame(8'(i), 1'b0, 1'b0));
        exp_q.push_back(8'h15);
        pulse_on_check = 1'b1;
        send_bits(mk_frame(8'h15, 1'b0, 1'b0), 11);
        pulse_on_check = 1'b0;
        repeat (5) @(negedge CLK);
        chk("t6_ovf", ovf_seen, exp_ovf);
        chk("t6_head", code, 8'h12);
        ready_mode = 1;
        drain("t6_drain");

        // randomized frames with a randomly stalling consumer
        ready_mode = 2;
        for (int i = 0; i < 14; i++) begin
            logic [7:0] b;
            int kind;
            b = 8'($urandom_range(0, 255));
            kind = int'($urandom_range(0, 3));
            send_and_model(mk_frame(b, kind == 2, kind == 3));
        end
        ready_mode = 1;
        drain("rand_drain");
        chk("rand_err", err_seen, exp_err);
        chk("rand_ovf", ovf_seen, exp_ovf);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 device-to-host receiver for the keyboard port (keyboard_clock, keyboard_data).
- Synchronises both PS/2 lines into the CLK domain, deframes 11-bit frames, checks start/parity/stop, and buffers good scancode bytes in a small FIFO.
- Presents bytes to the downstream scancode/character logic through a valid/ready handshake.
- Sits directly between the top-level keyboard pins and the CPU-side keyboard consumer.

Parameters:
- TIMEOUT_CYCLES, 32000, CLK cycles without a falling keyboard_clock edge before an in-progress frame is abandoned (2 ms at 16 MHz).
- FIFO_DEPTH, 4, number of buffered bytes; power of two, minimum 2.

Ports:
- CLK  input  1  system clock, 16 MHz.
- reset  input  1  synchronous, active-high reset.
- keyboard_clock  input  1  raw PS/2 clock, asynchronous, idle high.
- keyboard_data  input  1  raw PS/2 data, asynchronous, idle high.
- code  output  8  scancode at FIFO head.
- code_valid  output  1  FIFO non-empty.
- code_ready  input  1  consumer accepts code this cycle.
- frame_error  output  1  one-cycle pulse on bad start, parity, stop or timeout.
- overflow  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.

Behaviour:
Interface and reset:
- One clock. Reset is synchronous and active-high.
- Reset state: sync flops = 1, state IDLE, bit counter 0, timeout counter 0, FIFO empty with storage cleared.
- Output reset values: code=8'h00, code_valid=0, frame_error=0, overflow=0.

Synchronisation and edge detection:
- Each PS/2 line passes through 2 sync flops, plus a 3rd flop on the clock line.
- A falling edge (fe) is the cycle where sync stage 2 = 0 and stage 3 = 1.
- keyboard_data is sampled from its sync stage 2 in the fe cycle.

State machine (IDLE, RECEIVE, CHECK):
- IDLE: fe with data=0 -> RECEIVE, bit counter cleared, timeout counter cleared. fe with data=1 -> frame_error pulse, stay IDLE.
- RECEIVE: on each fe, store the bit and increment the bit counter.
  - Bits 0-7 are data, LSB first, shifted into the data register.
  - Bit 8 is parity; bit 9 is stop.
  - The fe carrying bit 9 moves to CHECK.
- RECEIVE timeout: the timeout counter increments each cycle without fe and clears on fe. Reaching TIMEOUT_CYCLES -> frame_error pulse, return to IDLE, discard partial byte.
- CHECK (exactly 1 cycle): good = (XOR of data and parity == 1) and (stop == 1).
  - good -> push the byte.
  - not good -> frame_error pulse, no push.
  - Always -> IDLE.

FIFO:
- code = head entry. code_valid = !empty.
- Pop when code_valid && code_ready. Pop with code_valid=0 has no effect.
- Push when full without a same-cycle pop -> byte dropped, overflow pulse, FIFO contents unchanged.
- Push and pop in the same cycle while full -> both occur, no overflow.
- Push and pop in the same cycle while empty -> push only (nothing to pop).
- Pointers wrap modulo FIFO_DEPTH. Full/empty are distinguished by an extra pointer bit or an occupancy counter.

Latency:
- Let edge k be the first CLK edge that samples keyboard_clock low on the stop bit.
- CHECK occurs in the cycle after edge k+2.
- code_valid rises after edge k+3 when the FIFO was previously empty.

Other boundary cases:
- Reset mid-frame: partial frame discarded, no frame_error and no output. The next complete frame is received normally.
- frame_error and overflow never assert in the same cycle.
- keyboard_data changes between edges are ignored.

Test Plan:
1. Send frame for 0x1C (start 0, data 00111000 LSB-first, parity 0, stop 1), code_ready=1 -> code=0x1C with code_valid for exactly 1 cycle; frame_error=0.
2. Send 0x1C with parity bit 1 -> single frame_error pulse; code_valid stays 0.
3. Hold code_ready=0 and send 0x01,0x02,0x03,0x04,0x05 -> one overflow pulse after the 5th frame; then raise code_ready -> codes 0x01,0x02,0x03,0x04 in order; code_valid falls after 4 pops.
4. Send start plus 4 bits, then idle -> frame_error exactly TIMEOUT_CYCLES cycles after the last fe; a following full 0xF0 frame -> code=0xF0, no error.
5. Assert reset for 1 cycle after 6 bits of 0xE0, then send full 0x5A -> only 0x5A appears; no frame_error.
6. FIFO full (0x11..0x14), code_ready=1 in the CHECK cycle of frame 0x15 -> no overflow; output order 0x11,0x12,0x13,0x14,0x15.
